// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch controller and its skid buffer.
package if_pkg;

   localparam int          INST_W      = 32;
   localparam logic [31:0] IF_RESET_PC = 32'd0;
   localparam logic [31:0] IF_NOP      = 32'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_DROP
   } if_state_e;

endpackage

// File: rtl/if_fetch_controller_skid.sv
// One-entry holding register for a word fetched while IF/ID is frozen.
// Clear wins over load.
module if_skid_buffer
   import if_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [INST_W-1:0] d_inst,
   input  logic [ADDR_W-1:0] d_pc,
   output logic              valid,
   output logic [INST_W-1:0] q_inst,
   output logic [ADDR_W-1:0] q_pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         q_inst <= IF_NOP;
         q_pc   <= '0;
      end else if (clear) begin
         valid  <= 1'b0;
      end else if (load) begin
         valid  <= 1'b1;
         q_inst <= d_inst;
         q_pc   <= d_pc;
      end
   end

endmodule

// File: rtl/if_fetch_controller.sv
// IF stage fetch sequencer: pc, imem req/ack, IF/ID output register,
// freeze via a one-entry skid buffer, and branch redirect/flush.
module if_fetch_controller
   import if_pkg::*;
#(
   parameter int               ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [INST_W-1:0] mem_rdata,
   output logic              if_valid,
   output logic [INST_W-1:0] if_inst,
   output logic [ADDR_W-1:0] if_pc
);

   if_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] drop_q, drop_d;
   logic              valid_q, valid_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] ifpc_q, ifpc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_al;

   logic              buf_load, buf_clear, buf_valid;
   logic [INST_W-1:0] buf_inst;
   logic [ADDR_W-1:0] buf_pc;

   assign pc_inc = pc_q + ADDR_W'(4);
   assign pc_al  = {pc_q[ADDR_W-1:2], 2'b00};

   // DROP keeps presenting the abandoned address until its ack.
   assign mem_req  = (state_q == S_REQ) || (state_q == S_DROP);
   assign mem_addr = (state_q == S_DROP) ? drop_q : pc_al;
   assign if_valid = valid_q;
   assign if_inst  = inst_q;
   assign if_pc    = ifpc_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      drop_d    = drop_q;
      valid_d   = valid_q;
      inst_d    = inst_q;
      ifpc_d    = ifpc_q;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (branch_taken) pc_d = branch_addr;
            state_d = S_REQ;
         end
         S_REQ: begin
            if (branch_taken) begin
               pc_d      = branch_addr;
               valid_d   = 1'b0;
               buf_clear = 1'b1;
               if (!mem_ack) begin
                  drop_d  = pc_al;
                  state_d = S_DROP;
               end
            end else if (mem_ack) begin
               pc_d = pc_inc;
               if (!valid_q || !freeze) begin
                  inst_d  = mem_rdata;
                  ifpc_d  = pc_inc;
                  valid_d = 1'b1;
               end else begin
                  buf_load = 1'b1;
                  state_d  = S_HOLD;
               end
            end else if (!freeze) begin
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (branch_taken) begin
               pc_d      = branch_addr;
               valid_d   = 1'b0;
               buf_clear = 1'b1;
               state_d   = S_REQ;
            end else if (!freeze) begin
               inst_d    = buf_inst;
               ifpc_d    = buf_pc;
               valid_d   = buf_valid;
               buf_clear = 1'b1;
               state_d   = S_REQ;
            end
         end
         S_DROP: begin
            valid_d = 1'b0;
            if (branch_taken) begin
               pc_d      = branch_addr;
               buf_clear = 1'b1;
            end
            if (mem_ack) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
         valid_q <= 1'b0;
         inst_q  <= IF_NOP;
         ifpc_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         valid_q <= valid_d;
         inst_q  <= inst_d;
         ifpc_q  <= ifpc_d;
      end
   end

   if_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (buf_load),
      .clear  (buf_clear),
      .d_inst (mem_rdata),
      .d_pc   (pc_inc),
      .valid  (buf_valid),
      .q_inst (buf_inst),
      .q_pc   (buf_pc)
   );

endmodule

// File: doc/if_fetch_controller.md
Name: if_fetch_controller

Overview:
Sequences instruction fetch for the IF stage. Owns the program counter, issues word-aligned read requests to the instruction memory over a req/ack handshake, and presents fetched instructions to IF/ID through a valid-qualified output register. Also handles pipeline freeze (hazard stall) and branch redirect/flush. Sits between the hazard unit/EX branch logic and the instruction memory.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset.
ADDR_W, 32, PC/address width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
freeze  in  1  hazard stall: IF/ID must hold its contents.
branch_taken  in  1  redirect request from EX.
branch_addr  in  ADDR_W  redirect target.
mem_req  out  1  instruction read request.
mem_addr  out  ADDR_W  read address, always {pc[31:2],2'b00}.
mem_ack  in  1  read data valid this cycle; may be asserted in the same cycle as mem_req (zero wait states).
mem_rdata  in  32  instruction word, sampled only when mem_ack=1.
if_valid  out  1  if_inst/if_pc hold a live instruction.
if_inst  out  32  fetched instruction.
if_pc  out  ADDR_W  fetch address + 4.

Behaviour:
- Reset is asynchronous, active-low: pc_q=RESET_PC, state=IDLE, buffer empty. Outputs: mem_req=0, if_valid=0, if_inst=0, if_pc=0.
- States: IDLE, REQ, HOLD, DROP.
- IDLE:
  - Lasts exactly one cycle after reset release, then goes to REQ.
  - branch_taken in IDLE loads pc_q=branch_addr.
- REQ:
  - mem_req=1, mem_addr=aligned pc_q.
  - Handshake rule: once raised, mem_req and mem_addr stay stable until mem_ack.
- On mem_ack in REQ, with no branch:
  - If the output register is free (if_valid=0 or freeze=0): if_inst=mem_rdata, if_pc=pc_q+4, if_valid=1, pc_q+=4. Stay in REQ.
  - Otherwise (if_valid=1 and freeze=1): capture data and pc into the 1-entry buffer, pc_q+=4, go to HOLD.
- REQ with freeze=0 and no ack: if_valid=0 next cycle (bubble).
- freeze=1 with if_valid=1: if_inst, if_pc and if_valid are held unchanged.
- HOLD:
  - mem_req=0.
  - When freeze=0: buffer moves to the output register (if_valid=1), buffer empties, go to REQ.
- Branch (branch_taken=1) takes priority over freeze and over mem_ack:
  - pc_q=branch_addr, if_valid=0 next cycle, buffer cleared.
  - From REQ with mem_ack=1 this cycle: discard mem_rdata, go to REQ (new address next cycle).
  - From REQ with no ack: go to DROP.
  - From HOLD: go to REQ.
  - From DROP: update pc_q, stay in DROP.
- DROP:
  - mem_req stays 1 with the old address (handshake rule).
  - On mem_ack: discard data, go to REQ with pc_q.
- pc arithmetic is modulo 2^ADDR_W; 32'hFFFFFFFC+4 wraps to 0.
- A branch_addr that is not word-aligned is stored as-is; only mem_addr is aligned, and if_pc = pc_q+4 unaligned.
- Reset asserted mid-transaction aborts immediately. The memory must tolerate mem_req dropping without ack under reset.
- Throughput with zero-wait memory and no stalls: one instruction per cycle; first if_valid=1 in the 2nd cycle after reset release.

Decomposition:
- Shared package (if_pkg): state encoding typedef (IDLE/REQ/HOLD/DROP), RESET_PC default, INST_W=32, the NOP word 32'd0.
- One natural sub-module: if_skid_buffer, the 1-entry data+pc holding register with load/clear/valid. Everything else (FSM, pc register, output register) stays in the top.

Test Plan:
- Zero-wait memory, no freeze -> mem_addr 0,4,8,12 on consecutive cycles; if_pc 4,8,12,16; if_valid stays 1 from cycle 2.
- 2-wait memory (ack on 3rd cycle of req) -> mem_addr stable for 3 cycles, one bubble pair between instructions, each if_inst equals the acked mem_rdata.
- freeze=1 for 3 cycles while if_valid=1, zero-wait memory -> if_inst/if_pc unchanged; exactly one extra word buffered (HOLD, mem_req=0); after release, outputs advance with no lost or duplicated instruction.
- branch_taken, branch_addr=32'h40, issued during a 2-wait fetch of 0x8 -> mem_addr stays 0x8 until ack, data discarded, next request to 0x40, if_pc=0x44, no 0x8 instruction ever valid.
- branch_taken and freeze together with if_valid=1 -> if_valid=0 next cycle, pc_q=branch_addr; branch wins.
- rst_n pulsed low mid-request, and pc at 32'hFFFFFFFC -> all outputs zero asynchronously; wrap case fetches next from 0.
